// File: rtl/sipo_deser.sv
// MSB-first serial-to-parallel deserializer with frame-start alignment, a single
// valid/ready holding register, optional even parity and sticky error flags.
module sipo_deser #(
    parameter int WIDTH     = 8,
    parameter bit PARITY_EN = 1'b0
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             i_sin_valid,
    input  logic             i_sin_bit,
    input  logic             i_sin_start,
    output logic [WIDTH-1:0] o_out_data,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic             o_busy,
    output logic             o_overflow,
    output logic             o_parity_err,
    input  logic             i_clr_err
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DATA = 2'd1,
        S_PAR  = 2'd2
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_shreg;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_out_data;
    logic               r_out_valid;
    logic               r_overflow;
    logic               r_parity_err;

    logic [WIDTH-1:0]   w_shift;
    logic [WIDTH-1:0]   w_first;
    logic [WIDTH-1:0]   w_word;
    logic               w_last_data;
    logic               w_complete;
    logic               w_par_bad;
    logic               w_load;
    logic               w_drop;
    logic               w_xfer;

    // Even parity: data bits plus parity bit must XOR to zero.
    function automatic logic f_par_fail(input logic [WIDTH-1:0] d, input logic p);
        return (^d) ^ p;
    endfunction

    always_comb begin
        w_shift     = {r_shreg[WIDTH-2:0], i_sin_bit};
        w_first     = {{(WIDTH-1){1'b0}}, i_sin_bit};
        w_last_data = (r_cnt == CNT_W'(WIDTH - 1));
        w_complete  = 1'b0;
        w_par_bad   = 1'b0;
        w_word      = w_shift;
        if (i_sin_valid && !i_sin_start) begin
            case (r_state)
                S_DATA: begin
                    if (w_last_data && !PARITY_EN) begin
                        w_complete = 1'b1;
                    end
                end
                S_PAR: begin
                    if (f_par_fail(r_shreg, i_sin_bit)) begin
                        w_par_bad = 1'b1;
                    end else begin
                        w_complete = 1'b1;
                        w_word     = r_shreg;
                    end
                end
                default: ;
            endcase
        end
        w_xfer = r_out_valid && i_out_ready;
        // A transfer in the same cycle frees the holding register for the new word.
        w_load = w_complete && (!r_out_valid || i_out_ready);
        w_drop = w_complete && !w_load;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state      <= S_IDLE;
            r_shreg      <= '0;
            r_cnt        <= '0;
            r_out_data   <= '0;
            r_out_valid  <= 1'b0;
            r_overflow   <= 1'b0;
            r_parity_err <= 1'b0;
        end else begin
            if (i_sin_valid) begin
                case (r_state)
                    S_IDLE: begin
                        if (i_sin_start) begin
                            r_shreg <= w_first;
                            r_cnt   <= CNT_W'(1);
                            r_state <= S_DATA;
                        end
                    end
                    S_DATA: begin
                        if (i_sin_start) begin
                            r_shreg <= w_first;
                            r_cnt   <= CNT_W'(1);
                        end else begin
                            r_shreg <= w_shift;
                            r_cnt   <= r_cnt + CNT_W'(1);
                            if (w_last_data) begin
                                r_state <= PARITY_EN ? S_PAR : S_IDLE;
                            end
                        end
                    end
                    S_PAR: begin
                        if (i_sin_start) begin
                            r_shreg <= w_first;
                            r_cnt   <= CNT_W'(1);
                            r_state <= S_DATA;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end

            if (w_load) begin
                r_out_data  <= w_word;
                r_out_valid <= 1'b1;
            end else if (w_xfer) begin
                r_out_valid <= 1'b0;
            end

            // Clear first so a coincident error event still sets its flag.
            if (i_clr_err) begin
                r_overflow   <= 1'b0;
                r_parity_err <= 1'b0;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
            if (w_par_bad) begin
                r_parity_err <= 1'b1;
            end
        end
    end

    assign o_out_data   = r_out_data;
    assign o_out_valid  = r_out_valid;
    assign o_busy       = (r_state != S_IDLE);
    assign o_overflow   = r_overflow;
    assign o_parity_err = r_parity_err;

endmodule
